// File: rtl/insn_fetch_pkg.sv
// Shared constants and the fetch FSM state type for the instruction fetch unit.
package insn_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSN_NOP         = 32'h0000_0013;
    localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } fetch_state_e;

endpackage

// File: rtl/insn_fetch_fifo.sv
// Synchronous in-order FIFO with push/pop/clear; DEPTH must be a power of two.
module insn_fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] storage_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = storage_q[rd_ptr_q];

    always_comb begin
        do_push  = push & ~full & ~clear;
        do_pop   = pop & ~empty & ~clear;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) storage_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/insn_fetch.sv
// Instruction fetch unit: PC, credit-limited imem requests, in-order response buffer, redirect flush.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module insn_fetch
    import insn_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flushed,
`endif
    output logic        insn_valid,
    input  logic        insn_ready,
    output logic [31:0] insn,
    output logic [31:0] insn_pc
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] outstanding, outstanding_next, out_count;
    logic [CW:0]   in_use;
    logic          credit_ok, req_fire, resp_fire, resp_push, insn_pop;
    logic [31:0]   pcq_head;
    logic [63:0]   out_head;
    logic          out_empty;
    logic          unused_pcq_full, unused_pcq_empty, unused_out_full;

    assign in_use           = {1'b0, outstanding} + {1'b0, out_count};
    assign credit_ok        = in_use < (CW + 1)'(FIFO_DEPTH);
    assign req_fire         = imem_req_valid & imem_req_ready;
    assign resp_fire        = imem_resp_valid & (outstanding != '0);
    assign resp_push        = resp_fire & (state_q == RUN) & ~redirect_valid;
    assign insn_pop         = insn_valid & insn_ready;
    assign outstanding_next = outstanding + CW'(req_fire) - CW'(resp_fire);

    // Request-PC queue: its occupancy is the outstanding count, and it is never
    // cleared so that stale in-flight responses can still be matched and dropped.
    insn_fetch_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_pc_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (1'b0),
        .push  (req_fire),
        .pop   (resp_fire),
        .wdata (pc_q),
        .rdata (pcq_head),
        .count (outstanding),
        .full  (unused_pcq_full),
        .empty (unused_pcq_empty)
    );

    insn_fetch_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (redirect_valid),
        .push  (resp_push),
        .pop   (insn_pop),
        .wdata ({imem_resp_data, pcq_head}),
        .rdata (out_head),
        .count (out_count),
        .full  (unused_out_full),
        .empty (out_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC & PC_ALIGN_MASK;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            IDLE:    state_d = RUN;
            RUN: begin
                if (redirect_valid) state_d = (outstanding_next == '0) ? RUN : FLUSH;
            end
            FLUSH: begin
                if (outstanding_next == '0) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
        // A redirect wins over the pc+4 of a request accepted in the same cycle.
        if (redirect_valid)  pc_d = redirect_pc & PC_ALIGN_MASK;
        else if (req_fire)   pc_d = pc_q + 32'd4;
    end

    always_comb begin
        imem_req_valid = (state_q == RUN) & credit_ok;
        imem_req_addr  = imem_req_valid ? pc_q : '0;
        insn_valid     = ~out_empty & ~redirect_valid;
        insn           = insn_valid ? out_head[63:32] : '0;
        insn_pc        = insn_valid ? out_head[31:0]  : '0;
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stall_q,   perf_stall_d;
    logic [31:0] perf_flushed_q, perf_flushed_d;
    logic        resp_discard;

    always_comb begin
        resp_discard   = resp_fire & ((state_q == FLUSH) | ((state_q == RUN) & redirect_valid));
        perf_fetched_d = perf_fetched_q + 32'(insn_pop);
        perf_stall_d   = perf_stall_q + 32'(insn_ready & ~insn_valid);
        perf_flushed_d = perf_flushed_q + 32'(resp_discard)
                         + (redirect_valid ? 32'(out_count) : 32'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
            perf_flushed_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
            perf_flushed_q <= perf_flushed_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
    assign perf_flushed = perf_flushed_q;
`endif

    resp_needs_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        imem_resp_valid |-> (outstanding != '0));

endmodule

// File: doc/insn_fetch.md
Name: insn_fetch

Overview:
- Instruction fetch unit: the producer feeding the instruction decoder.
- Holds the PC and issues word-aligned requests to instruction memory.
- Buffers returned words with their PCs in a small in-order FIFO.
- Presents {insn, insn_pc} to decode over a valid/ready handshake; handles redirects (branch/jump) by flushing buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] ignored.
- FIFO_DEPTH, 2, FIFO entries and maximum outstanding-plus-buffered fetches; power of two, >= 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  fetch address, bits [1:0] always 0.
- imem_resp_valid  in  1  response word valid; in order, >= 1 cycle after request accept.
- imem_resp_data  in  32  response instruction word.
- redirect_valid  in  1  load new PC, flush pipeline.
- redirect_pc  in  32  new PC; bits [1:0] forced to 0.
- insn_valid  out  1  instruction available to decode.
- insn_ready  in  1  decode accepts instruction.
- insn  out  32  instruction word to decoder.
- insn_pc  out  32  PC of insn.

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, state=IDLE, FIFO empty, outstanding=0. All outputs 0 during reset.
- Counters: outstanding counts accepted requests not yet responded, width $clog2(FIFO_DEPTH)+1.
- Credit rule: imem_req_valid=1 only in RUN and when outstanding+fifo_count < FIFO_DEPTH. Request accepted when imem_req_valid & imem_req_ready; on accept, pc<=pc+4, wrapping 32'hFFFF_FFFC -> 0. imem_req_addr=pc.
- Response: on imem_resp_valid in RUN, push {imem_resp_data, pc_of_request} into the FIFO. Request PCs are tracked in a PC queue parallel to outstanding.
- Response with zero outstanding is a protocol error; ignore it. An assertion flags it in simulation.
- Output: insn_valid = FIFO non-empty & ~redirect_valid. insn/insn_pc come from the FIFO head. Pop on insn_valid & insn_ready.
- Latency: response captured at edge N, insn_valid high after edge N; minimum request-to-insn latency 2 cycles.
- Simultaneous push/pop on a full FIFO is impossible by the credit rule. Push and pop in the same cycle are both honoured.
- States (typedef enum):
  - IDLE: one cycle after reset, no request. -> RUN.
  - RUN: issue and accept as above. On redirect_valid: pc<=redirect_pc, FIFO cleared. If outstanding (after this cycle's accept/response) = 0, stay RUN; else -> FLUSH.
  - FLUSH: no requests issued. Responses are discarded and decrement outstanding. -> RUN when outstanding reaches 0 (including a response this cycle). A new redirect_valid only updates pc.
- Redirect priority:
  - Overrides the request accept and pc+4 in the same cycle. A request accepted in the redirect cycle still counts as outstanding and is discarded later.
  - Overrides insn handshake (insn_valid masked).
  - Overrides a same-cycle push (response dropped).
- Reset mid-operation: all state cleared immediately, outstanding forgotten. The memory side is required to be reset together with this block.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched (32, increments per insn pop), perf_stall (32, increments per cycle with insn_ready=1 & insn_valid=0), and perf_flushed (32, increments per discarded response or flushed FIFO entry; increments by count on redirect). All reset to 0, wrap on overflow.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- constants.sv gains `RESET_PC_DEFAULT`, `INSN_NOP` (32'h0000_0013, used by the bench only), and the fetch state typedef {IDLE, RUN, FLUSH}.
- Natural sub-module: fetch_fifo, a parameterised synchronous FIFO with push/pop/clear, count, full, and empty. It is instantiated for the output buffer; the request-PC queue reuses it.

Test Plan:
- Reset release, memory always ready, 1-cycle response returning addr^32'hA5A5_0000, insn_ready=1 -> requests 0x0,0x4,0x8…; first insn_valid 2 cycles after first accept; insn_pc/insn pairs match in order.
- insn_ready=0 for 10 cycles -> exactly FIFO_DEPTH requests issued, then imem_req_valid=0; on release, 2 instructions drain in order with no loss.
- Redirect to 0x1002 with 2 outstanding, 3-cycle memory latency -> FSM enters FLUSH, both stale responses discarded, next request addr 0x1000, first delivered insn_pc=0x1000.
- Redirect coincident with insn_valid & insn_ready and a response -> no pop counted, response dropped, FIFO empty next cycle.
- pc=32'hFFFF_FFF8 via redirect -> requests FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst_n asserted mid-fetch with outstanding=2 -> outputs 0 immediately; after release, fetch restarts at RESET_PC; with FETCH_PERF_CNT_EN, counters read 0.
